// File: rtl/ppm_if.sv
// Upstream handshake bundle for the PPM transmitter: word + send strobe in,
// busy/done status and the LED line drive out.
interface ppm_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              send;
  logic              busy;
  logic              done;
  logic              pulse_out;

  modport master (
    output data,
    output send,
    input  busy,
    input  done,
    input  pulse_out
  );

  modport slave (
    input  data,
    input  send,
    output busy,
    output done,
    output pulse_out
  );
endinterface

// File: rtl/ppm_tx.sv
// PPM transmitter: start pulse, guard gap, then DATA_W/2 four-slot symbols,
// MSB pair first. Phase timing uses a single down-counter reloaded per phase.
module ppm_tx #(
  parameter int DATA_W    = 8,
  parameter int SLOT_CYC  = 16,
  parameter int PULSE_CYC = 4,
  parameter int START_CYC = 32
) (
  input  logic clk,
  input  logic rst_n,
  ppm_if.slave bus
);

  localparam int SYM_CYC = 4 * SLOT_CYC;
  localparam int CNT_MAX = ((START_CYC > SYM_CYC) ? START_CYC : SYM_CYC) - 1;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam int NSYM    = DATA_W / 2;
  localparam int IDX_W   = (NSYM < 2) ? 1 : $clog2(NSYM);

  localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(SLOT_CYC - 1);
  localparam logic [CNT_W-1:0] SYM_LOAD   = CNT_W'(SYM_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NSYM - 1);

  typedef enum logic [1:0] {IDLE, START, GAP, SYM} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [DATA_W-1:0] shreg_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              pulse_reg;

  logic [1:0] pos_cur;
  logic [1:0] pos_next;

  assign pos_cur = shreg_reg[DATA_W-1 -: 2];

  // Position of the symbol that follows the current one (after the 2-bit shift).
  generate
    if (DATA_W >= 4) begin : g_next_pos
      assign pos_next = shreg_reg[DATA_W-3 -: 2];
    end else begin : g_single_sym
      assign pos_next = 2'b00;
    end
  endgenerate

  // Line level for the symbol cycle whose down-counter value is 'remaining'.
  function automatic logic pulse_at(input logic [CNT_W-1:0] remaining,
                                    input logic [1:0]       pos);
    int cyc;
    int lo;
    cyc = SYM_CYC - 1 - int'(remaining);
    lo  = int'(pos) * SLOT_CYC;
    return (cyc >= lo) && (cyc < lo + PULSE_CYC);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shreg_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.send) begin
            shreg_reg <= bus.data;
            cnt_reg   <= START_LOAD;
            state_reg <= START;
            busy_reg  <= 1'b1;
            pulse_reg <= 1'b1;
          end
        end
        START: begin
          if (cnt_reg == '0) begin
            cnt_reg   <= GAP_LOAD;
            state_reg <= GAP;
            pulse_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        GAP: begin
          if (cnt_reg == '0) begin
            cnt_reg   <= SYM_LOAD;
            idx_reg   <= '0;
            state_reg <= SYM;
            pulse_reg <= pulse_at(SYM_LOAD, pos_cur);
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        SYM: begin
          if (cnt_reg == '0) begin
            if (idx_reg == LAST_IDX) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              pulse_reg <= 1'b0;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              shreg_reg <= shreg_reg << 2;
              cnt_reg   <= SYM_LOAD;
              pulse_reg <= pulse_at(SYM_LOAD, pos_next);
            end
          end else begin
            cnt_reg   <= cnt_reg - 1'b1;
            pulse_reg <= pulse_at(cnt_reg - 1'b1, pos_cur);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.pulse_out = pulse_reg;

endmodule

// File: doc/ppm_tx.md
# ppm_tx

Pulse-position-modulation transmitter for the optical link: it serializes one DATA_W-bit word into a start pulse, a guard gap, and DATA_W/2 four-slot PPM symbols on a single line driving the LED. It is the transmit end of the link whose receiver measures pulse intervals with up-counters. Timing comes from internal down-counters reloaded per phase. Upstream logic hands it a word with a one-cycle `send` strobe, and the block reports completion with `done`.

## Interface
- `DATA_W`, 8: payload bits per packet. Must be even and ≥2.
- `SLOT_CYC`, 16: clock cycles per PPM slot. Must be ≥2.
- `PULSE_CYC`, 4: high time of a data pulse, in cycles. Range 1..SLOT_CYC-1.
- `START_CYC`, 32: high time of the start pulse, in cycles. Must be ≥1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data`  in  DATA_W  word to transmit; sampled only when `send` is accepted.
- `send`  in  1  request strobe; accepted only in IDLE.
- `busy`  out  1  high while a packet is in flight.
- `done`  out  1  one-cycle pulse after the last symbol completes.
- `pulse_out`  out  1  line drive to the LED driver (1 = light on).

## Operation
- States: IDLE, START, GAP, SYM. All outputs are registered.
- Reset (async, any state): state=IDLE, `busy`=0, `done`=0, `pulse_out`=0, and shift register and counters cleared. A packet in progress is abandoned; no partial completion and no `done` are produced.
- IDLE with `send`=1: latch `data` into the shift register, load the phase counter with START_CYC-1, go to START.
- START: `pulse_out`=1, counter counts down. At 0, load SLOT_CYC-1 and go to GAP.
- GAP: `pulse_out`=0. At 0, go to SYM with symbol index 0 and the slot counter reloaded.
- SYM: each symbol is 4 slots of SLOT_CYC cycles.
  - Position p = top 2 bits of the shift register (MSB-first).
  - `pulse_out`=1 exactly during symbol cycles [p·SLOT_CYC, p·SLOT_CYC+PULSE_CYC), low otherwise.
  - After 4·SLOT_CYC cycles: shift left by 2 and increment the symbol index.
  - After symbol DATA_W/2-1: go to IDLE and pulse `done`.
- `send` while not in IDLE is ignored. `data` changes while busy have no effect.
- Counter widths: sized to hold max(START_CYC, 4·SLOT_CYC)-1 without overflow. The symbol index holds DATA_W/2-1.

## Timing
- Cycle 0 is the first cycle after the edge that samples `send`=1 in IDLE.
- `busy`=1 for cycles 0..T-1, where T = START_CYC + SLOT_CYC + 2·DATA_W·SLOT_CYC.
- Start pulse: high on cycles 0..START_CYC-1.
- Data pulse for symbol k with position p: rises at cycle START_CYC + SLOT_CYC + 4·SLOT_CYC·k + p·SLOT_CYC and stays high PULSE_CYC cycles.
- Cycle T: `done`=1, `busy`=0, `pulse_out`=0.
  - A `send`=1 sampled at the end of cycle T starts a new packet, so cycle T+1 is its cycle 0. This gives back-to-back packets with a one-cycle idle gap.
  - `done` and a new acceptance may coincide; the acceptance is honored.
- With defaults, T=304.
- No combinational path from inputs to outputs.

## Test plan
- Reset idle: assert `rst_n`=0 mid-cycle → `busy`=`done`=`pulse_out`=0 immediately; hold `send`=0 100 cycles after release → outputs stay 0.
- Single packet at defaults, `data`=8'hB4 (positions 2,3,1,0):
  - start pulse high cycles 0..31;
  - data pulses rising at cycles 80, 160, 192, 240, each 4 cycles wide;
  - `busy` high cycles 0..303; `done` high only on cycle 304.
- Extreme positions: `data`=8'h00 → pulses rise at 48, 112, 176, 240. `data`=8'hFF → pulses rise at 96, 160, 224, 288, and the last pulse ends at cycle 291.
- Ignored request: pulse `send` with `data`=8'hFF at cycle 100 of a packet carrying 8'hB4 → waveform identical to the 8'hB4 reference and exactly one `done`.
- Back-to-back: hold `send`=1 continuously with `data`=8'h1B → second packet's start pulse begins at cycle 305, exactly two `done` pulses by cycle 609.
- Reset mid-symbol: assert `rst_n`=0 at cycle 82 while `pulse_out`=1 → `pulse_out`=0 asynchronously, no `done`; a fresh `send` after release yields a full correct packet.
